// File: rtl/mips_pkg.sv
// mips_pkg: mult/div function codes and sequencer state encodings shared with decode and the ALU
package mips_pkg;
    localparam logic [3:0] MD_DIV   = 4'd0;
    localparam logic [3:0] MD_DIVU  = 4'd1;
    localparam logic [3:0] MD_MULT  = 4'd2;
    localparam logic [3:0] MD_MULTU = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} md_state_t;

    function automatic logic is_md_op(input logic [3:0] f);
        return f <= MD_MULTU;
    endfunction
endpackage

// File: rtl/md_step.sv
// md_step: one shift-add multiply step or one restoring divide step on the {hi,lo} accumulator
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mult,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   top;
    logic [WIDTH-1:0] sub;
    logic             borrow;

    // mult adds the multiplicand on the multiplier LSB then shifts right; div shifts left and trial-subtracts
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        top      = acc[2*WIDTH-1:WIDTH-1];
        borrow   = top < {1'b0, operand};
        sub      = top[WIDTH-1:0] - operand;
        acc_next = mult   ? {sum, acc[WIDTH-1:1]} :
                   borrow ? {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                            {sub, acc[WIDTH-2:0], 1'b1};
    end
endmodule

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative multiply/divide controller owning the architectural HI/LO registers
module mult_div_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       f,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_t          state, state_n;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   opb, a_raw, a_mag, b_mag, quo, rem, hi_n, lo_n;
    logic [CW-1:0]      cnt;
    logic               is_mult, neg_a, neg_b, sgn, neg_res;

    md_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opb),
        .mult     (is_mult),
        .acc_next (acc_step)
    );

    assign busy = state != IDLE;

    // state register; reset aborts any in-flight op immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state: cancel beats both the CALC progression and the FINISH write
    always_comb begin
        state_n = state;
        if (state == IDLE)      state_n = (start && !cancel && is_md_op(f)) ? CALC : IDLE;
        else if (cancel)        state_n = IDLE;
        else if (state == CALC) state_n = (cnt == CW'(WIDTH - 1)) ? FINISH : CALC;
        else                    state_n = IDLE;
    end

    // operand magnitudes on entry and signed fix-up of the magnitude result on exit
    always_comb begin
        sgn     = (f == MD_DIV) || (f == MD_MULT);
        a_mag   = (sgn && op1[WIDTH-1]) ? -op1 : op1;
        b_mag   = (sgn && op2[WIDTH-1]) ? -op2 : op2;
        neg_res = neg_a ^ neg_b;
        prod    = neg_res ? -acc : acc;
        quo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_n    = is_mult ? prod[2*WIDTH-1:WIDTH] : (opb == '0 ? a_raw : rem);
        lo_n    = is_mult ? prod[WIDTH-1:0]       : (opb == '0 ? '1 : quo);
    end

    // datapath: operand latch, per-step accumulator update, HI/LO commit and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            opb     <= '0;
            a_raw   <= '0;
            cnt     <= '0;
            is_mult <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == FINISH) && !cancel;
            if (state == IDLE && start && !cancel) begin
                if (is_md_op(f)) begin
                    is_mult <= f[1];
                    neg_a   <= sgn & op1[WIDTH-1];
                    neg_b   <= sgn & op2[WIDTH-1];
                    a_raw   <= op1;
                    opb     <= f[1] ? a_mag : b_mag;
                    acc     <= {{WIDTH{1'b0}}, f[1] ? b_mag : a_mag};
                    cnt     <= '0;
                end else if (f == MD_MTHI) begin
                    hi <= op1;
                end else if (f == MD_MTLO) begin
                    lo <= op1;
                end
            end
            if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (state == FINISH && !cancel) begin
                hi <= hi_n;
                lo <= lo_n;
            end
        end
    end
endmodule
